// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle RV32I ALU: single-cycle logic/arith ops,
// iterative 1-bit-per-cycle shifter, result held until consumed.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic               ready,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [WIDTH-1:0]   register_data_1,
    input  logic [WIDTH-1:0]   register_data_2,
    output logic [WIDTH-1:0]   register_data_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_valid;
    logic               r_illegal;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_left;
    logic               r_arith;

    logic               w_f7_zero;
    logic               w_f7_alt;
    logic               w_illegal;
    logic               w_is_shift;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]   w_step;

    assign w_f7_zero  = (funct7 == 7'd0);
    assign w_f7_alt   = (funct7 == 7'd32);
    assign w_illegal  = !(w_f7_zero || w_f7_alt) ||
                        (w_f7_alt && funct3 != 3'b000 && funct3 != 3'b101);
    assign w_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign w_shamt    = register_data_2[SHAMT_W-1:0];

    // Shift cases only reach here with shamt == 0, so they pass rs1 through.
    always_comb begin
        w_result = '0;
        case (funct3)
            3'b000: w_result = w_f7_alt ? register_data_1 - register_data_2
                                        : register_data_1 + register_data_2;
            3'b001: w_result = register_data_1;
            3'b010: w_result = {{(WIDTH-1){1'b0}},
                                $signed(register_data_1) < $signed(register_data_2)};
            3'b011: w_result = {{(WIDTH-1){1'b0}},
                                register_data_1 < register_data_2};
            3'b100: w_result = register_data_1 ^ register_data_2;
            3'b101: w_result = register_data_1;
            3'b110: w_result = register_data_1 | register_data_2;
            3'b111: w_result = register_data_1 & register_data_2;
            default: w_result = '0;
        endcase
    end

    assign w_step = r_left ? {r_shreg[WIDTH-2:0], 1'b0}
                           : {r_arith & r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_left    <= 1'b0;
            r_arith   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        if (w_illegal) begin
                            r_out     <= '0;
                            r_illegal <= 1'b1;
                            r_valid   <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_is_shift && w_shamt != '0) begin
                            r_shreg <= register_data_1;
                            r_cnt   <= w_shamt;
                            r_left  <= (funct3 == 3'b001);
                            r_arith <= w_f7_alt;
                            r_state <= S_SHIFT;
                        end else begin
                            r_out   <= w_result;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_shreg <= w_step;
                    r_cnt   <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_out   <= w_step;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_valid   <= 1'b0;
                        r_illegal <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready             = (r_state == S_IDLE);
    assign register_data_out = r_out;
    assign out_valid         = r_valid;
    assign illegal           = r_illegal;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle: ops, shift latency,
// hold/ignore behaviour, illegal encodings and reset mid-shift.
module tb_alu_multicycle;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        ready;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] register_data_1;
    logic [31:0] register_data_2;
    logic [31:0] register_data_out;
    logic        out_valid;
    logic        out_ready;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .ready(ready),
        .funct3(funct3),
        .funct7(funct7),
        .register_data_1(register_data_1),
        .register_data_2(register_data_2),
        .register_data_out(register_data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present a request for one edge; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        funct3 = f3;
        funct7 = f7;
        register_data_1 = a;
        register_data_2 = b;
        enable = 1'b1;
        @(posedge clock);
        @(negedge clock);
        enable = 1'b0;
    endtask

    // Latency in edges counted from (and including) the acceptance edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (register_data_out !== 32'h0) begin
            errors++; $display("FAIL reset_out got %h want 0", register_data_out);
        end
        checks++;
        if (illegal !== 1'b0) begin
            errors++; $display("FAIL reset_illegal got %b want 0", illegal);
        end
        reset = 1'b0;
        enable = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_add();
        int lat;
        issue(3'b000, 7'd0, 32'd1, 32'd2);
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL add_ready_low got %b want 0", ready);
        end
        wait_valid(lat);
        checks++;
        if (lat != 1) begin
            errors++; $display("FAIL add_latency got %0d want 1", lat);
        end
        checks++;
        if (register_data_out !== 32'h3 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_result got %h/%b want 00000003/0",
                     register_data_out, illegal);
        end
        handoff();
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_handoff got rdy=%b vld=%b want 1/0",
                     ready, out_valid);
        end
        checks++;
        if (register_data_out !== 32'h3) begin
            errors++;
            $display("FAIL add_out_kept got %h want 00000003", register_data_out);
        end
    endtask

    task automatic test_arith();
        logic [2:0]  f3 [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
        logic [6:0]  f7 [6] = '{7'd32, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        logic [31:0] a  [6] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hF0F0_1234, 32'hF000_000F, 32'hF0F0_FFFF};
        logic [31:0] b  [6] = '{32'h2, 32'h1, 32'h1,
                                32'h0FF0_4321, 32'h0000_FF00, 32'h0FFF_00F0};
        logic [31:0] ex [6] = '{32'hFFFF_FFFF, 32'h1, 32'h0,
                                32'hFF00_5115, 32'hF000_FF0F, 32'h00F0_00F0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(f3[i], f7[i], a[i], b[i]);
            wait_valid(lat);
            checks++;
            if (lat != 1 || register_data_out !== ex[i]) begin
                errors++;
                $display("FAIL arith_%0d got %h lat %0d want %h lat 1",
                         i, register_data_out, lat, ex[i]);
            end
            handoff();
        end
    endtask

    task automatic test_shifts();
        logic [2:0]  f3 [4] = '{3'b101, 3'b101, 3'b001, 3'b001};
        logic [6:0]  f7 [4] = '{7'd32, 7'd0, 7'd0, 7'd0};
        logic [31:0] a  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1234_5678};
        logic [31:0] b  [4] = '{32'd4, 32'd4, 32'd31, 32'hFFFF_FFE0};
        logic [31:0] ex [4] = '{32'hF800_0000, 32'h0800_0000,
                                32'h8000_0000, 32'h1234_5678};
        int          el [4] = '{5, 5, 32, 1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(f3[i], f7[i], a[i], b[i]);
            wait_valid(lat);
            checks++;
            if (lat != el[i]) begin
                errors++;
                $display("FAIL shift_lat_%0d got %0d want %0d", i, lat, el[i]);
            end
            checks++;
            if (register_data_out !== ex[i]) begin
                errors++;
                $display("FAIL shift_res_%0d got %h want %h",
                         i, register_data_out, ex[i]);
            end
            handoff();
        end
    endtask

    task automatic test_hold();
        int lat;
        issue(3'b000, 7'd0, 32'd10, 32'd20);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b0;
            enable = i[0];
            funct3 = 3'(i);
            register_data_1 = $urandom;
            register_data_2 = $urandom;
            @(negedge clock);
            checks++;
            if (register_data_out !== 32'd30 || out_valid !== 1'b1 ||
                ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got %h vld=%b rdy=%b want 0000001e/1/0",
                         i, register_data_out, out_valid, ready);
            end
        end
        enable = 1'b0;
        handoff();
        issue(3'b101, 7'd0, 32'h8000_0000, 32'd4);
        funct3 = 3'b000;
        funct7 = 7'd32;
        register_data_1 = 32'h1234_5678;
        register_data_2 = 32'd1;
        enable = 1'b1;
        wait_valid(lat);
        enable = 1'b0;
        checks++;
        if (lat != 5 || register_data_out !== 32'h0800_0000) begin
            errors++;
            $display("FAIL midshift_ops got %h lat %0d want 08000000 lat 5",
                     register_data_out, lat);
        end
        handoff();
    endtask

    task automatic test_illegal();
        logic [2:0] f3 [2] = '{3'b000, 3'b100};
        logic [6:0] f7 [2] = '{7'd1, 7'd32};
        int lat;
        for (int i = 0; i < 2; i++) begin
            issue(f3[i], f7[i], 32'h1111_1111, 32'h2222_2222);
            wait_valid(lat);
            checks++;
            if (lat != 1 || illegal !== 1'b1 || register_data_out !== 32'h0) begin
                errors++;
                $display("FAIL illegal_%0d got ill=%b out=%h lat %0d want 1/0/1",
                         i, illegal, register_data_out, lat);
            end
            handoff();
            checks++;
            if (illegal !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal_clr_%0d got ill=%b rdy=%b want 0/1",
                         i, illegal, ready);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        issue(3'b000, 7'd0, 32'd3, 32'd4);
        wait_valid(lat);
        handoff();
        issue(3'b001, 7'd0, 32'd1, 32'd20);
        repeat (6) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || ready !== 1'b0 || register_data_out !== 32'd7) begin
            errors++;
            $display("FAIL in_shift got vld=%b rdy=%b out=%h want 0/0/00000007",
                     out_valid, ready, register_data_out);
        end
        reset = 1'b1;
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0 || register_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b vld=%b out=%h want 1/0/0",
                     ready, out_valid, register_data_out);
        end
        reset = 1'b0;
        enable = 1'b0;
        issue(3'b000, 7'd0, 32'd5, 32'd7);
        wait_valid(lat);
        checks++;
        if (lat != 1 || register_data_out !== 32'h0000_000C) begin
            errors++;
            $display("FAIL post_reset_add got %h lat %0d want 0000000c lat 1",
                     register_data_out, lat);
        end
        handoff();
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        funct3 = 3'b000;
        funct7 = 7'd0;
        register_data_1 = '0;
        register_data_2 = '0;
        test_reset();
        test_add();
        test_arith();
        test_shifts();
        test_hold();
        test_illegal();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
